// File: rtl/prince_sbox_layer_ti_cotg_pkg.sv
// Shared types, constants and the 4-share threshold component functions for the
// PRINCE S-box layer. Component k never reads input share k.
package prince_ti_pkg;

  localparam int NIBBLES              = 16;
  localparam int SHARES               = 4;
  localparam int RAND_W               = 12;
  localparam int PRIME_CYCLES_DEFAULT = 16;

  typedef logic [63:0] share_t;
  typedef logic [3:0]  nibble_t;

  typedef enum logic [0:0] {
    PRIME = 1'b0,
    RUN   = 1'b1
  } fsm_t;

  // Element x is S(x): B,F,3,2,A,C,9,1,6,7,8,0,E,5,D,4
  localparam logic [15:0][3:0] PRINCE_SBOX = 64'h4D5E_0876_19CA_23FB;

  // Algebraic normal form of each S-box output bit (Moebius transform).
  // Bit m of row b is the coefficient of the monomial selected by mask m.
  function automatic logic [3:0][15:0] sbox_anf();
    logic [3:0][15:0] t;
    for (int b = 0; b < 4; b++) begin
      for (int x = 0; x < 16; x++) begin
        t[b][x] = PRINCE_SBOX[x][b];
      end
      for (int i = 0; i < 4; i++) begin
        for (int x = 0; x < 16; x++) begin
          if (x[i]) t[b][x] = t[b][x] ^ t[b][x ^ (1 << i)];
        end
      end
    end
    return t;
  endfunction

  localparam logic [3:0][15:0] PRINCE_ANF = sbox_anf();

  // Direct sharing: every share-product term of every monomial is owned by the
  // lowest-numbered component whose own share does not appear in the term.
  // The S-box is cubic, so each term touches at most three shares and has an owner.
  function automatic nibble_t ti_component(input logic [1:0] k,
                                           input nibble_t sa, input nibble_t sb,
                                           input nibble_t sc);
    nibble_t    sh [4];
    nibble_t    r;
    logic       term;
    logic       ok;
    logic [3:0] used;
    logic [3:0] mv;
    logic [7:0] av;
    logic [1:0] idx;
    logic [2:0] owner;
    case (k)
      2'd0:    sh = '{4'h0, sa, sb, sc};
      2'd1:    sh = '{sa, 4'h0, sb, sc};
      2'd2:    sh = '{sa, sb, 4'h0, sc};
      default: sh = '{sa, sb, sc, 4'h0};
    endcase
    r = '0;
    for (int b = 0; b < 4; b++) begin
      for (int m = 0; m < 16; m++) begin
        mv = 4'(m);
        if (PRINCE_ANF[b][m]) begin
          for (int a = 0; a < 256; a++) begin
            av   = 8'(a);
            term = 1'b1;
            ok   = 1'b1;
            used = '0;
            for (int v = 0; v < 4; v++) begin
              idx = av[2*v +: 2];
              if (mv[v]) begin
                term      = term & sh[idx][v];
                used[idx] = 1'b1;
              end else if (idx != 2'd0) begin
                ok = 1'b0;
              end
            end
            owner = 3'd4;
            for (int i = 3; i >= 0; i--) begin
              if (!used[i]) owner = {1'b0, 2'(i)};
            end
            if (ok && (owner == {1'b0, k})) r[b] = r[b] ^ term;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic nibble_t comp_w(input nibble_t a1, input nibble_t a2, input nibble_t a3);
    return ti_component(2'd0, a1, a2, a3);
  endfunction

  function automatic nibble_t comp_x(input nibble_t a0, input nibble_t a2, input nibble_t a3);
    return ti_component(2'd1, a0, a2, a3);
  endfunction

  function automatic nibble_t comp_y(input nibble_t a0, input nibble_t a1, input nibble_t a3);
    return ti_component(2'd2, a0, a1, a3);
  endfunction

  function automatic nibble_t comp_z(input nibble_t a0, input nibble_t a1, input nibble_t a2);
    return ti_component(2'd3, a0, a1, a2);
  endfunction

endpackage

// File: rtl/prince_sbox_layer_ti_cotg_if.sv
// Handshake and share bus of the S-box layer.
// Both sides use valid/ready: a beat moves on a rising clk edge where valid && ready.
interface prince_sbox_layer_ti_cotg_if;
  import prince_ti_pkg::*;

  logic              in_valid;
  logic              in_ready;
  share_t            share0, share1, share2, share3;
  logic [RAND_W-1:0] fresh_rand;
  logic              out_valid;
  logic              out_ready;
  share_t            out_share0, out_share1, out_share2, out_share3;

  modport slave (
    input  in_valid, share0, share1, share2, share3, fresh_rand, out_ready,
    output in_ready, out_valid, out_share0, out_share1, out_share2, out_share3
  );

  modport master (
    output in_valid, share0, share1, share2, share3, fresh_rand, out_ready,
    input  in_ready, out_valid, out_share0, out_share1, out_share2, out_share3
  );
endinterface

// File: rtl/prince_sbox_layer_ti_cotg_nibble.sv
// One shared S-box nibble: four non-complete components, each masked by its guard.
module prince_sbox_ti_nibble
  import prince_ti_pkg::*;
(
  input  nibble_t a0_i,
  input  nibble_t a1_i,
  input  nibble_t a2_i,
  input  nibble_t a3_i,
  input  nibble_t d0_i,
  input  nibble_t d1_i,
  input  nibble_t d2_i,
  input  nibble_t d3_i,
  output nibble_t o0_o,
  output nibble_t o1_o,
  output nibble_t o2_o,
  output nibble_t o3_o
);
  assign o0_o = comp_w(a1_i, a2_i, a3_i) ^ d0_i;
  assign o1_o = comp_x(a0_i, a2_i, a3_i) ^ d1_i;
  assign o2_o = comp_y(a0_i, a1_i, a3_i) ^ d2_i;
  assign o3_o = comp_z(a0_i, a1_i, a2_i) ^ d3_i;
endmodule

// File: rtl/prince_sbox_layer_ti_cotg.sv
// Registered 4-share TI S-box layer with changing-of-the-guards remasking.
// Optional PRINCE_TI_RAND_ALARM_EN adds a sticky alarm for stuck-at-zero fresh randomness.
module prince_sbox_layer_ti_cotg
  import prince_ti_pkg::*;
#(
  parameter int PRIME_CYCLES = PRIME_CYCLES_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  prince_sbox_layer_ti_cotg_if.slave   bus,
  output fsm_t                         dbg_state_o
`ifdef PRINCE_TI_RAND_ALARM_EN
  ,
  output logic                         rand_alarm
`endif
);
  localparam int CNT_W = (PRIME_CYCLES > 1) ? $clog2(PRIME_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRIME_CYCLES - 1);

  fsm_t             state_q;
  logic [CNT_W-1:0] prime_cnt_q;
  logic             out_valid_q;
  share_t           out_q  [SHARES];
  share_t           comp_d [SHARES];
  logic             in_ready;
  logic             accept;

  assign in_ready = (state_q == RUN) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // Guards of nibble j are the previous nibble of the current output register;
  // nibble 0 has no predecessor and takes fresh randomness instead.
  for (genvar j = 0; j < NIBBLES; j++) begin : g_nib
    nibble_t d1, d2, d3;
    if (j == 0) begin : g_fresh
      assign d1 = bus.fresh_rand[3:0];
      assign d2 = bus.fresh_rand[7:4];
      assign d3 = bus.fresh_rand[11:8];
    end else begin : g_chain
      assign d1 = out_q[0][4*(j-1) +: 4];
      assign d2 = out_q[1][4*(j-1) +: 4];
      assign d3 = out_q[2][4*(j-1) +: 4];
    end
    prince_sbox_ti_nibble u_nib (
      .a0_i (bus.share0[4*j +: 4]),
      .a1_i (bus.share1[4*j +: 4]),
      .a2_i (bus.share2[4*j +: 4]),
      .a3_i (bus.share3[4*j +: 4]),
      .d0_i (d1 ^ d2 ^ d3),
      .d1_i (d1),
      .d2_i (d2),
      .d3_i (d3),
      .o0_o (comp_d[0][4*j +: 4]),
      .o1_o (comp_d[1][4*j +: 4]),
      .o2_o (comp_d[2][4*j +: 4]),
      .o3_o (comp_d[3][4*j +: 4])
    );
  end

  // Priming shifts fresh randomness through shares 0..2 so the first guards are random.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PRIME;
      prime_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '{default: '0};
    end else begin
      case (state_q)
        PRIME: begin
          {out_q[2], out_q[1], out_q[0]} <= {bus.fresh_rand, out_q[2], out_q[1], out_q[0][63:RAND_W]};
          prime_cnt_q <= prime_cnt_q + CNT_W'(1);
          if (prime_cnt_q == CNT_LAST) state_q <= RUN;
        end
        RUN: begin
          if (accept) begin
            out_q       <= comp_d;
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= PRIME;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_share0 = out_q[0];
  assign bus.out_share1 = out_q[1];
  assign bus.out_share2 = out_q[2];
  assign bus.out_share3 = out_q[3];
  assign dbg_state_o    = state_q;

`ifdef PRINCE_TI_RAND_ALARM_EN
  logic [1:0] zero_run_q;
  logic       rand_alarm_q;
  logic       consume;

  assign consume = (state_q == PRIME) || accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_run_q   <= '0;
      rand_alarm_q <= 1'b0;
    end else if (consume) begin
      if (bus.fresh_rand == '0) begin
        if (zero_run_q == 2'd3) rand_alarm_q <= 1'b1;
        else                    zero_run_q   <= zero_run_q + 2'd1;
      end else begin
        zero_run_q <= '0;
      end
    end
  end

  assign rand_alarm = rand_alarm_q;
`endif
endmodule

// File: tb/tb_prince_sbox_layer_ti_cotg.sv
// Directed bench for the shared PRINCE S-box layer: priming length and contents,
// unshared results, stall behaviour, guard refresh and reset while busy.
module tb_prince_sbox_layer_ti_cotg;
  import prince_ti_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prince_sbox_layer_ti_cotg_if bus();
  fsm_t dbg_state;
`ifdef PRINCE_TI_RAND_ALARM_EN
  logic rand_alarm;
`endif

  prince_sbox_layer_ti_cotg dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
`ifdef PRINCE_TI_RAND_ALARM_EN
    ,
    .rand_alarm  (rand_alarm)
`endif
  );

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] unshared();
    return bus.out_share0 ^ bus.out_share1 ^ bus.out_share2 ^ bus.out_share3;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // driver: share x with masks r1..r3, wait for in_ready, transfer, check unshared output
  task automatic send(input string tag, input logic [63:0] x, input logic [63:0] r1,
                      input logic [63:0] r2, input logic [63:0] r3,
                      input logic [63:0] exp_u, input logic [11:0] fr);
    int n;
    bus.share1     = r1;
    bus.share2     = r2;
    bus.share3     = r3;
    bus.share0     = x ^ r1 ^ r2 ^ r3;
    bus.fresh_rand = fr;
    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b1;
    exp_q.push_back(exp_u);
    #1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      check({tag, "_timeout"}, 64'(bus.in_ready), 64'd1);
      void'(exp_q.pop_front());
    end else begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
      check(tag, unshared(), exp_q.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [63:0] a0, a1, a2, a3;
    logic [63:0] vec_x [4];
    logic [63:0] vec_s [4];
    vec_x = '{64'h0000_0000_0000_0000, 64'h0123_4567_89AB_CDEF,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hA5A5_A5A5_A5A5_A5A5};
    vec_s = '{64'hBBBB_BBBB_BBBB_BBBB, 64'hBF32_AC91_6780_E5D4,
              64'h4444_4444_4444_4444, 64'h8C8C_8C8C_8C8C_8C8C};

    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b1;
    bus.fresh_rand = 12'hA5C;
    bus.share0 = '0; bus.share1 = '0; bus.share2 = '0; bus.share3 = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(PRIME));
    check("rst_share3", bus.out_share3, 64'd0);
    rst = 1'b0;

    // priming: in_ready low for exactly 16 cycles
    n = 0;
    while (!bus.in_ready && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    check("prime_len", 64'(n), 64'd16);
    check("prime_share0", bus.out_share0, 64'hCA5C_A5CA_5CA5_CA5C);
    check("prime_share1", bus.out_share1, 64'h5CA5_CA5C_A5CA_5CA5);
    check("prime_share2", bus.out_share2, 64'hA5CA_5CA5_CA5C_A5CA);
    check("prime_share3", bus.out_share3, 64'd0);
    check("prime_valid", 64'(bus.out_valid), 64'd0);

    // first accept in cycle 17 with all-zero shares
    @(posedge clk); #1;
    check("first_valid", 64'(bus.out_valid), 64'd1);
    check("first_zero", unshared(), 64'hBBBB_BBBB_BBBB_BBBB);

    // directed vectors under random sharings
    for (int i = 0; i < 4; i++) begin
      send($sformatf("vec%0d", i), vec_x[i], rnd64(), rnd64(), rnd64(), vec_s[i], 12'($urandom_range(1, 4095)));
    end

    // stall: out_valid held for 5 cycles, no accept
    bus.out_ready = 1'b0;
    bus.share1 = rnd64(); bus.share2 = rnd64(); bus.share3 = rnd64();
    bus.share0 = 64'hFEDC_BA98_7654_3210 ^ bus.share1 ^ bus.share2 ^ bus.share3;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_ready", 64'(bus.in_ready), 64'd0);
      check("stall_valid", 64'(bus.out_valid), 64'd1);
      check("stall_data", unshared(), vec_s[3]);
    end
    bus.out_ready = 1'b1;
    #1;
    check("release_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("release_data", unshared(), 64'h4D5E_0876_19CA_23FB);

    // identical sharing twice with different fresh randomness
    send("pair_a", 64'h0011_2233_4455_6677, 64'h1357_9BDF_0246_8ACE,
         64'hDEAD_BEEF_0BAD_F00D, 64'h0F1E_2D3C_4B5A_6978, 64'hBBFF_3322_AACC_9911, 12'h123);
    a0 = bus.out_share0; a1 = bus.out_share1; a2 = bus.out_share2; a3 = bus.out_share3;
    send("pair_b", 64'h0011_2233_4455_6677, 64'h1357_9BDF_0246_8ACE,
         64'hDEAD_BEEF_0BAD_F00D, 64'h0F1E_2D3C_4B5A_6978, 64'hBBFF_3322_AACC_9911, 12'h456);
    check("pair_differs",
          64'({a0, a1, a2, a3} != {bus.out_share0, bus.out_share1, bus.out_share2, bus.out_share3}),
          64'd1);

    // reset while an output is pending; prime with all-zero randomness
    bus.out_ready  = 1'b0;
    bus.in_valid   = 1'b0;
    bus.fresh_rand = 12'h000;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_ready", 64'(bus.in_ready), 64'd0);
    check("midrst_share0", bus.out_share0, 64'd0);
`ifdef PRINCE_TI_RAND_ALARM_EN
    check("alarm_rst", 64'(rand_alarm), 64'd0);
`endif
    rst = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      n++;
      @(posedge clk); #1;
`ifdef PRINCE_TI_RAND_ALARM_EN
      if (n == 3) check("alarm_3zero", 64'(rand_alarm), 64'd0);
      if (n == 4) check("alarm_4zero", 64'(rand_alarm), 64'd1);
`endif
    end
    check("prime_len2", 64'(n), 64'd16);
    check("prime2_share2", bus.out_share2, 64'd0);

    send("post_rst", vec_x[1], rnd64(), rnd64(), rnd64(), vec_s[1], 12'h3C7);
`ifdef PRINCE_TI_RAND_ALARM_EN
    check("alarm_sticky", 64'(rand_alarm), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
